cpu_control_fsm: RTL and testbench

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm.sv | 133 +++++++++++++
 tb/tb_cpu_control_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Instruction sequencer for a small accumulator CPU: walks FETCH/DECODE/MREAD/EXEC/MWRITE
// and drives the datapath strobes, with sticky illegal-opcode and retired-instruction tracking.
module cpu_control_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       accZero,
    output logic       irLoad,
    output logic       pcInc,
    output logic       pcLoad,
    output logic       mReadFlag,
    output logic       mWriteFlag,
    output logic       accLoad,
    output logic       accSel,
    output logic [2:0] aluOp,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state,
    output logic [7:0] instCount
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        MREAD   = 3'd3,
        EXEC    = 3'd4,
        MWRITE  = 3'd5,
        HALT    = 3'd6,
        UNREACH = 3'd7
    } state_t;

    state_t     state_reg, state_next, done_next;
    logic [3:0] op_reg;
    logic [7:0] count_reg;
    logic       illegal_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            op_reg      <= 4'd0;
            count_reg   <= 8'd0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                op_reg <= opcode;
                if (count_reg != 8'hFF)
                    count_reg <= count_reg + 8'd1;
                if (opcode >= 4'hB && opcode <= 4'hE)
                    illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        irLoad     = 1'b0;
        pcInc      = 1'b0;
        pcLoad     = 1'b0;
        mReadFlag  = 1'b0;
        mWriteFlag = 1'b0;
        accLoad    = 1'b0;
        accSel     = 1'b0;
        aluOp      = 3'd7;
        halted     = 1'b0;
        state_next = state_reg;
        done_next  = run ? FETCH : IDLE;

        case (state_reg)
            IDLE: begin
                if (run)
                    state_next = FETCH;
            end
            FETCH: begin
                irLoad     = 1'b1;
                state_next = DECODE;
            end
            // opReg only captures at the end of DECODE, so DECODE strobes use the live opcode.
            DECODE: begin
                case (opcode)
                    4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_next = MREAD;
                    4'h2: state_next = MWRITE;
                    4'h8: state_next = EXEC;
                    4'h9: begin
                        pcLoad     = 1'b1;
                        state_next = done_next;
                    end
                    4'hA: begin
                        pcLoad     = accZero;
                        pcInc      = ~accZero;
                        state_next = done_next;
                    end
                    4'hF: state_next = HALT;
                    default: begin
                        pcInc      = 1'b1;
                        state_next = done_next;
                    end
                endcase
            end
            MREAD: begin
                mReadFlag  = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                accLoad = 1'b1;
                pcInc   = 1'b1;
                if (op_reg == 4'h1)
                    accSel = 1'b1;
                else if (op_reg == 4'h8)
                    aluOp = 3'd5;
                else
                    aluOp = 3'(op_reg - 4'd3);
                state_next = done_next;
            end
            MWRITE: begin
                mWriteFlag = 1'b1;
                pcInc      = 1'b1;
                state_next = done_next;
            end
            HALT: begin
                halted     = 1'b1;
                state_next = HALT;
            end
            default: state_next = IDLE;
        endcase
    end

    assign state     = state_reg;
    assign illegal   = illegal_reg;
    assign instCount = count_reg;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized scoreboard bench for cpu_control_fsm: an instruction-level model queues
// the expected per-cycle output vector and a monitor compares it on each falling edge.
module tb_cpu_control_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic       accZero;
    logic       irLoad, pcInc, pcLoad, mReadFlag, mWriteFlag, accLoad, accSel;
    logic [2:0] aluOp;
    logic       halted, illegal;
    logic [2:0] state;
    logic [7:0] instCount;

    cpu_control_fsm dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .accZero(accZero),
        .irLoad(irLoad), .pcInc(pcInc), .pcLoad(pcLoad), .mReadFlag(mReadFlag),
        .mWriteFlag(mWriteFlag), .accLoad(accLoad), .accSel(accSel), .aluOp(aluOp),
        .halted(halted), .illegal(illegal), .state(state), .instCount(instCount)
    );

    always #5 clock = ~clock;

    // vector: state[3] strobes[7] aluOp[3] halted illegal instCount[8]
    typedef logic [22:0] vec_t;
    localparam logic [6:0] S_IR = 7'b1000000, S_PI = 7'b0100000, S_PL = 7'b0010000,
                           S_MR = 7'b0001000, S_MW = 7'b0000100, S_AL = 7'b0000010,
                           S_AS = 7'b0000001;

    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_cnt;
    logic m_ill;
    logic m_fetch;

    function automatic vec_t ex(input logic [2:0] st, input logic [6:0] strb, input logic [2:0] alu);
        return {st, strb, alu, (st == 3'd6), m_ill, m_cnt[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
        end
    endtask

    initial begin : monitor
        vec_t e, a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, irLoad, pcInc, pcLoad, mReadFlag, mWriteFlag, accLoad, accSel,
                     aluOp, halted, illegal, instCount};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle_vector state=%0d act=%h exp=%h", e[22:20], a, e);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [3:0] op, input logic az, input vec_t e);
        @(posedge clock);
        #1;
        run     = r;
        opcode  = op;
        accZero = az;
        exp_q.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom);
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, rop(), rbit(), ex(3'd0, 7'd0, 3'd7));
    endtask

    // Expands one instruction into its expected cycle sequence from the ISA table.
    task automatic do_instr(input logic [3:0] op, input logic az, input logic rend);
        logic [6:0] s;
        logic       fin;
        if (!m_fetch)
            cyc(1'b1, rop(), rbit(), ex(3'd0, 7'd0, 3'd7));
        cyc(rbit(), rop(), rbit(), ex(3'd1, S_IR, 3'd7));
        s   = 7'd0;
        fin = 1'b0;
        if (op == 4'h0 || (op >= 4'hB && op <= 4'hE)) begin s = S_PI; fin = 1'b1; end
        else if (op == 4'h9) begin s = S_PL; fin = 1'b1; end
        else if (op == 4'hA) begin s = az ? S_PL : S_PI; fin = 1'b1; end
        cyc(fin ? rend : rbit(), op, az, ex(3'd2, s, 3'd7));
        if (m_cnt < 255) m_cnt++;
        if (op >= 4'hB && op <= 4'hE) m_ill = 1'b1;
        if (op == 4'h1)
            cyc(rbit(), rop(), rbit(), ex(3'd3, S_MR, 3'd7));
        if (op >= 4'h3 && op <= 4'h7)
            cyc(rbit(), rop(), rbit(), ex(3'd3, S_MR, 3'd7));
        if (op == 4'h1)
            cyc(rend, rop(), rbit(), ex(3'd4, S_AL | S_AS | S_PI, 3'd7));
        else if (op >= 4'h3 && op <= 4'h7)
            cyc(rend, rop(), rbit(), ex(3'd4, S_AL | S_PI, 3'(op - 4'd3)));
        else if (op == 4'h8)
            cyc(rend, rop(), rbit(), ex(3'd4, S_AL | S_PI, 3'd5));
        else if (op == 4'h2)
            cyc(rend, rop(), rbit(), ex(3'd5, S_MW | S_PI, 3'd7));
        m_fetch = rend;
        $display("instr op=%h accZero=%0d run_end=%0d count=%0d", op, az, rend, m_cnt);
    endtask

    // Asserts reset just after a falling edge and checks outputs clear before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b0;
        run   = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_mwrite"}, 32'(mWriteFlag), 32'd0);
        chk({tag, "_strobes"}, 32'({irLoad, pcInc, pcLoad, mReadFlag, accLoad, accSel}), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_count"}, 32'(instCount), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset   = 1'b1;
        m_cnt   = 0;
        m_ill   = 1'b0;
        m_fetch = 1'b0;
        $display("reset %s done", tag);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset   = 1'b0;
        run     = 1'b0;
        opcode  = 4'd0;
        accZero = 1'b0;
        m_cnt   = 0;
        m_ill   = 1'b0;
        m_fetch = 1'b0;
        #1;
        chk("por_state", 32'(state), 32'd0);
        chk("por_aluop", 32'(aluOp), 32'd7);
        chk("por_count", 32'(instCount), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        idle_cycles(3);
        do_instr(4'h1, 1'b0, 1'b1);
        do_instr(4'h4, 1'b0, 1'b1);
        do_instr(4'h8, 1'b1, 1'b1);
        do_instr(4'hA, 1'b1, 1'b1);
        do_instr(4'hA, 1'b0, 1'b1);
        do_instr(4'h9, 1'b0, 1'b1);
        do_instr(4'h2, 1'b0, 1'b0);
        idle_cycles(2);
        do_instr(4'hC, 1'b0, 1'b1);
        do_instr(4'h0, 1'b0, 1'b1);
        do_instr(4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            do_instr(4'($urandom_range(0, 14)), rbit(), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 300; i++)
            do_instr(4'h0, rbit(), 1'b1);

        // Reset in the middle of an STA's MWRITE cycle.
        do_instr(4'h0, 1'b0, 1'b1);
        cyc(rbit(), rop(), rbit(), ex(3'd1, S_IR, 3'd7));
        cyc(rbit(), 4'h2, rbit(), ex(3'd2, 7'd0, 3'd7));
        if (m_cnt < 255) m_cnt++;
        cyc(1'b1, rop(), rbit(), ex(3'd5, S_MW | S_PI, 3'd7));
        do_reset("mwrite_rst");

        idle_cycles(2);
        do_instr(4'h3, 1'b0, 1'b1);
        do_instr(4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            cyc(rbit(), rop(), rbit(), ex(3'd6, 7'd0, 3'd7));
        do_reset("halt_rst");
        idle_cycles(1);
        do_instr(4'h7, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clock);
        @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
